fft_result_master: RTL
======================

# fft_result_master

Avalon-MM write initiator that drains the FFT result RAM to host memory once a transform completes. It sits on the FFT output side and is the counterpart to the Avalon slave that loads input samples. On a `start` pulse, typically tied to `fft_done`, it reads `NUM_WORDS` 32-bit results from the result RAM, one word at a time. It issues one Avalon-MM write per word to consecutive word addresses from a latched base address, honours `avm_waitrequest`, and pulses `done` when the last write is accepted.

## Interface
- `NUM_WORDS`, 512: number of result words transferred per run.
- `RAM_AW`, 9: result RAM address width; must satisfy 2^RAM_AW ≥ NUM_WORDS.
- `clk` input 1: single clock; all logic is posedge.
- `n_rst` input 1: reset, asynchronous, active-low.
- `start` input 1: single-cycle request to begin a run; honoured only in IDLE.
- `base_addr` input 32: byte address of the first write; latched on the accepted `start`.
- `ram_ren` output 1: result RAM read enable.
- `ram_raddr` output RAM_AW: result RAM read address.
- `ram_rdata` input 32: result RAM read data, valid the cycle after `ram_ren`.
- `avm_address` output 32: Avalon byte address.
- `avm_write` output 1: Avalon write request.
- `avm_writedata` output 32: Avalon write data.
- `avm_byteenable` output 4: constant 4'hF whenever `avm_write`=1, else 0.
- `avm_waitrequest` input 1: slave stall.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a run completes.

## Operation
- **Registers**
  - `idx`: RAM_AW+1 bits, the word index.
  - `base_q`: 32 bits, the latched base address.
  - `data_q`: 32 bits, the captured read data.
- **States:** IDLE, FETCH, LATCH, WRITE, FINISH. The encoding comes from the package enum.
- **IDLE**
  - Drives all outputs to 0.
  - On `start`=1: `base_q`←`base_addr`, `idx`←0, go to FETCH.
- **FETCH:** `ram_ren`=1, `ram_raddr`=`idx`[RAM_AW-1:0], go to LATCH.
- **LATCH:** `data_q`←`ram_rdata`, go to WRITE.
- **WRITE**
  - Outputs: `avm_write`=1, `avm_address`=`base_q`+(`idx`<<2), `avm_writedata`=`data_q`, `avm_byteenable`=4'hF.
  - While `avm_waitrequest`=1, stay in WRITE with all Avalon outputs held stable.
  - When `avm_waitrequest`=0 at a posedge, the write is accepted:
    - if `idx`==NUM_WORDS-1, go to FINISH;
    - otherwise `idx`←`idx`+1 and go to FETCH.
- **FINISH:** `done`=1 for exactly one cycle, then go to IDLE.
- **Address arithmetic:** modulo 2^32. A wrap past 32'hFFFFFFFC continues silently at 0.
- **`start` outside IDLE:** ignored, including in FINISH. It is not queued.
- **Reset mid-run:** asynchronous return to IDLE; every register and output is cleared immediately. A dropped `avm_write` is accepted behaviour. The next `start` restarts at `idx` 0.
- **Outstanding transactions:** exactly one at a time. There is no read path on the Avalon side and no bursts.

## Timing
- **Reset values:** all outputs 0, state IDLE, `idx`/`base_q`/`data_q` 0.
- **Per-word latency:** 3 cycles minimum (FETCH, LATCH, WRITE), plus 1 cycle per `avm_waitrequest` stall.
- **Cycle numbering:** with `start` sampled at edge 0, word k is presented in WRITE during cycle 3k+3 when there are no stalls.
- **`done`:**
  - With NUM_WORDS=512 and no stalls, `done` is high during cycle 1537 and `busy` returns low in cycle 1538.
  - Total stall cycles add 1:1 to the `done` time.
- **RAM read latency:** fixed at 1 cycle; `ram_rdata` is sampled only in LATCH.
- **Avalon outputs:** registered, or decoded from registered state only. There is no combinational path from `avm_waitrequest` to any output.

## Structure
- Shared package `fft_pkg` holds:
  - the `NUM_WORDS` / `RAM_AW` defaults;
  - enum `res_state_t` {IDLE, FETCH, LATCH, WRITE, FINISH};
  - constant `AVM_BE_ALL` = 4'hF.
- Single module, no sub-module. The index counter and address adder are inline.

## Test plan
- **Reset:** hold `n_rst`=0 with random inputs → all outputs 0. Release, hold `start`=0 for 10 cycles → outputs stay 0.
- **Full run, no stalls:** RAM[i]=i*32'h01010101, `base_addr`=32'h1000_0000, `start` pulse → 512 writes with address 32'h1000_0000+4i and data RAM[i]. `byteenable`=4'hF on every write. `done` is a single pulse in cycle 1537.
- **Stall:** `avm_waitrequest`=1 for 3 cycles on word 5 → address 32'h1000_0014 and data RAM[5] held for 4 cycles. Exactly one write counted. `done` at cycle 1540.
- **Ignored restart:** `start` pulse at cycle 200 with a different `base_addr` → no effect; addresses continue from the original base.
- **Address wrap:** `base_addr`=32'hFFFF_FFF8 → first four addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- **Reset mid-run:** assert `n_rst` during the WRITE of word 100 → outputs 0 asynchronously. A new `start` → first write goes to the new base with data RAM[0].

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared definitions for the FFT result drain path: default
//                transfer size, result-RAM address width, the result-master
//                state encoding and the Avalon all-lanes byte-enable value.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_NUM_WORDS = 512;
    localparam int FFT_RAM_AW    = 9;

    localparam logic [3:0] AVM_BE_ALL = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LATCH  = 3'd2,
        WRITE  = 3'd3,
        FINISH = 3'd4
    } res_state_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_result_master.sv
`default_nettype none
// ============================================================================
//  Module      : fft_result_master
//  Description : Avalon-MM write initiator that copies NUM_WORDS 32-bit words
//                from the FFT result RAM to consecutive host word addresses,
//                starting at a base address latched on the accepted start.
//                One word in flight at a time: FETCH -> LATCH -> WRITE.
//  Ports       : clk, n_rst           - clock, async active-low reset
//                start, base_addr     - run request and first byte address
//                ram_ren/raddr/rdata  - result RAM read port (1-cycle latency)
//                avm_*                - Avalon-MM write master
//                busy, done           - status (done is a 1-cycle pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_result_master
    import fft_pkg::*;
#(
    parameter int NUM_WORDS = FFT_NUM_WORDS,
    parameter int RAM_AW    = FFT_RAM_AW
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [31:0]       base_addr,
    output logic              ram_ren,
    output logic [RAM_AW-1:0] ram_raddr,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done
);

    localparam logic [RAM_AW:0] c_last_idx = (RAM_AW+1)'(NUM_WORDS - 1);

    res_state_t        r_state;
    logic [RAM_AW:0]   r_idx;
    logic [31:0]       r_base;
    logic [31:0]       r_data;

    logic [RAM_AW:0]   w_idx_inc;
    logic [31:0]       w_word_addr;

    assign w_idx_inc   = r_idx + 1'b1;
    // Byte address of the current word; the 32-bit add wraps silently.
    assign w_word_addr = r_base + {{(32-RAM_AW-3){1'b0}}, r_idx, 2'b00};

    // Write data and byte enables are gated by the registered write strobe,
    // so they are zero whenever no write is being presented.
    assign avm_writedata  = avm_write ? r_data     : 32'h0;
    assign avm_byteenable = avm_write ? AVM_BE_ALL : 4'h0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_base      <= 32'h0;
            r_data      <= 32'h0;
            ram_ren     <= 1'b0;
            ram_raddr   <= '0;
            avm_address <= 32'h0;
            avm_write   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base    <= base_addr;
                        r_idx     <= '0;
                        ram_ren   <= 1'b1;
                        ram_raddr <= '0;
                        busy      <= 1'b1;
                        r_state   <= FETCH;
                    end
                end
                FETCH: begin
                    // Read was issued during this cycle; data arrives next.
                    ram_ren   <= 1'b0;
                    ram_raddr <= '0;
                    r_state   <= LATCH;
                end
                LATCH: begin
                    r_data      <= ram_rdata;
                    avm_write   <= 1'b1;
                    avm_address <= w_word_addr;
                    r_state     <= WRITE;
                end
                WRITE: begin
                    // Outputs are left untouched while the slave stalls.
                    if (!avm_waitrequest) begin
                        avm_write   <= 1'b0;
                        avm_address <= 32'h0;
                        if (r_idx == c_last_idx) begin
                            done    <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_idx     <= w_idx_inc;
                            ram_ren   <= 1'b1;
                            ram_raddr <= w_idx_inc[RAM_AW-1:0];
                            r_state   <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : fft_result_master
`default_nettype wire
